icache_assoc: RTL

Parametrised set-associative instruction cache, successor to the direct-mapped instruction cache in the fetch path. It answers fetch lookups combinationally in the same cycle and accepts one fill per cycle from the memory controller. It adds configurable associativity with round-robin replacement, a single-cycle flush for `fence.i`/reset-of-context, and saturating hit/miss performance counters. Lines hold one instruction word (32-bit or compressed) at half-word granularity.

---
 rtl/icache_assoc.sv | 133 +++++++++++++
 1 files changed

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with round-robin replacement, single-cycle
// flush and saturating hit/miss counters. Lookups resolve in the same cycle.
module icache_assoc #(
  parameter int WAYS      = 2,
  parameter int SET_BITS  = 5,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 icache_get_ready,
  input  logic [31:0]          icache_get_addr,
  output logic                 hit,
  output logic [31:0]          icache_get_inst,
  output logic                 icache_get_is_c,
  input  logic                 wr_ready,
  input  logic                 wr_is_c,
  input  logic [31:0]          wr_addr,
  input  logic [31:0]          wr_inst,
  input  logic                 flush,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = 31 - SET_BITS;
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]  valid_q  [SETS];
  logic [PTR_W-1:0] ptr_q    [SETS];
  logic [TAG_W-1:0] tag_mem  [SETS][WAYS];
  logic [31:0]      data_mem [SETS][WAYS];
  logic             isc_mem  [SETS][WAYS];

  logic [SET_BITS-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0]    rd_tag, wr_tag;

  assign rd_idx = icache_get_addr[SET_BITS:1];
  assign rd_tag = icache_get_addr[31:SET_BITS+1];
  assign wr_idx = wr_addr[SET_BITS:1];
  assign wr_tag = wr_addr[31:SET_BITS+1];

  // Bit 0 of both addresses is below half-word granularity.
  logic unused_addr_bits;
  assign unused_addr_bits = icache_get_addr[0] ^ wr_addr[0];

  // Lookup: descending scan so the lowest matching way wins.
  logic             rd_found;
  logic [PTR_W-1:0] rd_way;

  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    rd_found = 1'b0;
    rd_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[rd_idx][w] && (tag_mem[rd_idx][w] == rd_tag)) begin
        rd_found = 1'b1;
        rd_way   = PTR_W'(w);
      end
    end
  end

  assign hit             = icache_get_ready && rd_found;
  assign icache_get_inst = hit ? data_mem[rd_idx][rd_way] : 32'h0;
  assign icache_get_is_c = hit ? isc_mem[rd_idx][rd_way] : 1'b0;

  // Fill target: matching way, else lowest free way, else the round-robin victim.
  logic             match_found, free_found, fill_advance;
  logic [PTR_W-1:0] match_way, free_way, wr_way, ptr_next;

  always_comb begin
    match_found = 1'b0;
    match_way   = '0;
    free_found  = 1'b0;
    free_way    = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[wr_idx][w] && (tag_mem[wr_idx][w] == wr_tag)) begin
        match_found = 1'b1;
        match_way   = PTR_W'(w);
      end
      if (!valid_q[wr_idx][w]) begin
        free_found = 1'b1;
        free_way   = PTR_W'(w);
      end
    end
    fill_advance = !match_found && !free_found;
    wr_way       = match_found ? match_way : (free_found ? free_way : ptr_q[wr_idx]);
    ptr_next     = (ptr_q[wr_idx] == PTR_W'(WAYS - 1)) ? '0 : ptr_q[wr_idx] + 1'b1;
  end

  logic fill_en, count_en;
  assign fill_en  = rdy_in && wr_ready && !flush;
  assign count_en = rdy_in && icache_get_ready && !flush;

  // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
          ptr_q[s]   <= '0;
        end
      end else if (wr_ready) begin
        valid_q[wr_idx][wr_way] <= 1'b1;
        if (fill_advance) ptr_q[wr_idx] <= ptr_next;
      end
      if (count_en) begin
        if (hit) begin
          if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
        end else begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
        end
      end
    end
  end

  // NOTE: tag/data arrays carry no reset; a line is only ever read through its valid bit.
  always_ff @(posedge clk_in) begin
    if (rst_in && fill_en) begin
      tag_mem[wr_idx][wr_way]  <= wr_tag;
      data_mem[wr_idx][wr_way] <= wr_inst;
      isc_mem[wr_idx][wr_way]  <= wr_is_c;
    end
  end

endmodule
